ddr3_init_sequencer: RTL
========================

// Module: ddr3_init_sequencer
// PURPOSE
//  Hardware DDR3 power-up/init sequencer driving DFI phase-0 in place of the software DFII injector.
//  Sequence: RESET# hold, CKE enable, MRS MR2/MR3/MR1/MR0(DLL reset)/MR0, tDLLK, ZQCL, tZQinit.
//  Then asserts init_done, which flips the DFI mux to the hardware memory controller (DFII SEL).
//  Sits between the PHY DFI input mux and the CSR bank (start/status).
// PARAMETERS
//  ADDR_W    14      DFI address width
//  BA_W      3       DFI bank width
//  TMR_W     20      internal timer width; every T_* must be in [1, 2**TMR_W-1]
//  MR0_DLL   'h320   MR0 value issued first (DLL reset set, BA=0)
//  MR0_VAL   'h220   MR0 value issued second (BA=0)
//  MR1_VAL   'h006   MR1 value (BA=1)
//  MR2_VAL   'h200   MR2 value (BA=2)
//  MR3_VAL   'h000   MR3 value (BA=3)
//  T_RESET   20000   cycles RESET# held low (200 us @100 MHz)
//  T_CKE     50000   cycles RESET# high before CKE rises (500 us)
//  T_XPR     32      cycles after CKE rise before first MRS
//  T_MRD     4       cycles per MRS state (tMRD)
//  T_MOD     12      cycles in final MR0 state (tMOD)
//  T_DLLK    600     cycles of DLL lock wait
//  T_ZQINIT  600     cycles after ZQCL before done
//  AUTO_START 1      1: sequence starts on first cycle after reset release
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse: (re)run sequence; ignored while busy
//  busy         out  1       sequence in progress
//  init_done    out  1       sequence complete; selects hardware controller on DFI
//  state_dbg    out  4       current state encoding (CSR readback)
//  dfi_reset_n  out  1       DRAM RESET#
//  dfi_cke      out  1       DRAM CKE
//  dfi_odt      out  1       DRAM ODT; held 0 by this block
//  dfi_cs_n     out  1       chip select
//  dfi_ras_n    out  1       RAS#
//  dfi_cas_n    out  1       CAS#
//  dfi_we_n     out  1       WE#
//  dfi_address  out  ADDR_W  address / MR value
//  dfi_bank     out  BA_W    bank / MR index
// BEHAVIOUR
//  Reset: dfi_reset_n=0, dfi_cke=0, dfi_odt=0, cs_n/ras_n/cas_n/we_n=1, address=0, bank=0,
//   busy=0, init_done=0, state=IDLE. All outputs registered.
//  States: IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0_DLL, MRS0, DLLK_WAIT,
//   ZQCL, ZQ_WAIT, DONE. Linear order; each timed state lasts exactly its T_* cycles.
//  Timer: loaded with T_x on state entry, decremented each cycle; state advances when it reads 1.
//  IDLE -> RST_HOLD on start, or on first post-reset cycle if AUTO_START=1.
//  RST_HOLD (T_RESET): reset_n=0, cke=0. CKE_WAIT (T_CKE): reset_n=1, cke=0.
//  XPR_WAIT (T_XPR): cke=1. cke stays 1 through DONE.
//  MRS2/MRS3/MRS1/MRS0_DLL (T_MRD each), MRS0 (T_MOD): MRS command (cs_n=ras_n=cas_n=we_n=0,
//   bank=MR index, address=MR value) on the FIRST cycle only; remaining cycles deselect (cs_n=1,
//   ras/cas/we=1). Address/bank hold value during deselect.
//  DLLK_WAIT (T_DLLK): deselect. ZQCL (1 cycle): cs_n=0, ras_n=1, cas_n=1, we_n=0, address=1<<10,
//   bank=0. ZQ_WAIT (T_ZQINIT): deselect.
//  DONE: init_done=1, busy=0, command pins deselect; stays until start or reset.
//  busy=1 in every state except IDLE and DONE. start while busy: ignored, no effect.
//  start in DONE: init_done drops next cycle, full re-run from RST_HOLD (reset_n, cke driven low).
//  Async reset mid-sequence: immediate return to reset values; no partial command completes.
//  dfi_odt constant 0; ODT ownership passes to controller with init_done.
// STRUCTURE
//  Shared include ddr3_dfi_defs.vh: state encodings, DFI command encodings (MRS, ZQCL, DESELECT),
//   MR index constants.
//  Sub-module ddr3_init_timer (TMR_W down-counter: load, value, expire) instantiated once.
//  FSM + registered DFI output stage in this module.
// TESTING (bench overrides T_RESET=4, T_CKE=5, T_XPR=3, T_MRD=4, T_MOD=6, T_DLLK=8, T_ZQINIT=7)
//  Reset, AUTO_START=1 -> reset_n low 4 cycles, high 5 cycles with cke=0, then cke=1; busy=1.
//  Full run -> exactly 5 MRS pulses in order BA2/'h200, BA3/'h000, BA1/'h006, BA0/'h320,
//   BA0/'h220, spaced 4,4,4,4 cycles; ZQCL A10=1 8+6 cycles after last MRS start... per T_MOD+T_DLLK.
//  Full run -> init_done rises exactly 4+5+3+16+6+8+1+7=50 cycles after reset release.
//  start pulse while busy (during MRS1) -> sequence timing and command list unchanged.
//  start in DONE -> init_done=0 next cycle, reset_n=0, cke=0; second full run identical to first.
//  rst_n low during DLLK_WAIT -> all outputs return to reset values same cycle, no further commands.

Source files
------------

// File: rtl/ddr3_init_sequencer_pkg.sv
// Shared definitions for the DDR3 init sequencer:
//   - state encodings (also exported on state_dbg for CSR readback)
//   - DFI command encodings {cs_n, ras_n, cas_n, we_n}
//   - mode-register index constants (driven on the bank pins during MRS)
package ddr3_init_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_HOLD  = 4'd1,
        ST_CKE_WAIT  = 4'd2,
        ST_XPR_WAIT  = 4'd3,
        ST_MRS2      = 4'd4,
        ST_MRS3      = 4'd5,
        ST_MRS1      = 4'd6,
        ST_MRS0_DLL  = 4'd7,
        ST_MRS0      = 4'd8,
        ST_DLLK_WAIT = 4'd9,
        ST_ZQCL      = 4'd10,
        ST_ZQ_WAIT   = 4'd11,
        ST_DONE      = 4'd12
    } state_e;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } dfi_cmd_t;

    localparam dfi_cmd_t CMD_MRS    = 4'b0000;
    localparam dfi_cmd_t CMD_ZQCL   = 4'b0110;
    localparam dfi_cmd_t CMD_DESEL  = 4'b1111;

    localparam int MR0_IDX = 0;
    localparam int MR1_IDX = 1;
    localparam int MR2_IDX = 2;
    localparam int MR3_IDX = 3;

    // ZQCL is distinguished from ZQCS by A10=1.
    localparam int ZQCL_A10_BIT = 10;

endpackage

// File: rtl/ddr3_init_timer.sv
// Down-counter that times each sequencer state.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (state entry)
//   load_val   : duration of the state being entered, in cycles
//   expire     : counter reads 1, i.e. this is the last cycle of the state
module ddr3_init_timer #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up/initialisation sequencer driving DFI phase 0.
// RESET# hold, CKE enable, MRS MR2/MR3/MR1/MR0(DLL reset)/MR0, tDLLK,
// ZQCL, tZQinit, then init_done hands the DFI mux to the memory controller.
//   clk, rst_n   : clock, async active-low reset
//   start        : pulse to (re)run; ignored while busy
//   busy         : sequence in progress (not IDLE/DONE)
//   init_done    : sequence complete
//   state_dbg    : current state encoding
//   dfi_*        : registered DFI phase-0 command/address outputs
module ddr3_init_sequencer
    import ddr3_init_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 14,
    parameter int unsigned       BA_W       = 3,
    parameter int unsigned       TMR_W      = 20,
    parameter logic [ADDR_W-1:0] MR0_DLL    = 'h320,
    parameter logic [ADDR_W-1:0] MR0_VAL    = 'h220,
    parameter logic [ADDR_W-1:0] MR1_VAL    = 'h006,
    parameter logic [ADDR_W-1:0] MR2_VAL    = 'h200,
    parameter logic [ADDR_W-1:0] MR3_VAL    = 'h000,
    parameter int unsigned       T_RESET    = 20000,
    parameter int unsigned       T_CKE      = 50000,
    parameter int unsigned       T_XPR      = 32,
    parameter int unsigned       T_MRD      = 4,
    parameter int unsigned       T_MOD      = 12,
    parameter int unsigned       T_DLLK     = 600,
    parameter int unsigned       T_ZQINIT   = 600,
    parameter bit                AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              init_done,
    output logic [3:0]        state_dbg,
    output logic              dfi_reset_n,
    output logic              dfi_cke,
    output logic              dfi_odt,
    output logic              dfi_cs_n,
    output logic              dfi_ras_n,
    output logic              dfi_cas_n,
    output logic              dfi_we_n,
    output logic [ADDR_W-1:0] dfi_address,
    output logic [BA_W-1:0]   dfi_bank
);

    state_e            state_q, state_d;
    logic              entry;
    logic              auto_arm;
    logic              tmr_expire;
    logic [TMR_W-1:0]  tmr_load_val;
    dfi_cmd_t          cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BA_W-1:0]   bank_d;

    ddr3_init_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (entry),
        .load_val (tmr_load_val),
        .expire   (tmr_expire)
    );

    // Every non-IDLE/DONE state is timed and advances linearly on expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start || auto_arm) state_d = ST_RST_HOLD;
            ST_DONE: if (start)             state_d = ST_RST_HOLD;
            default: if (tmr_expire)        state_d = state_e'(state_q + 4'd1);
        endcase
    end

    assign entry = (state_d != state_q);

    always_comb begin
        unique case (state_d)
            ST_RST_HOLD:  tmr_load_val = TMR_W'(T_RESET);
            ST_CKE_WAIT:  tmr_load_val = TMR_W'(T_CKE);
            ST_XPR_WAIT:  tmr_load_val = TMR_W'(T_XPR);
            ST_MRS2,
            ST_MRS3,
            ST_MRS1,
            ST_MRS0_DLL:  tmr_load_val = TMR_W'(T_MRD);
            ST_MRS0:      tmr_load_val = TMR_W'(T_MOD);
            ST_DLLK_WAIT: tmr_load_val = TMR_W'(T_DLLK);
            ST_ZQCL:      tmr_load_val = TMR_W'(1);
            ST_ZQ_WAIT:   tmr_load_val = TMR_W'(T_ZQINIT);
            default:      tmr_load_val = '0;
        endcase
    end

    // Commands go out only on the entry cycle of a command state; the rest
    // of the state deselects while address/bank keep their last value.
    always_comb begin
        cmd_d  = CMD_DESEL;
        addr_d = dfi_address;
        bank_d = dfi_bank;
        if (entry) begin
            unique case (state_d)
                ST_MRS2:     begin cmd_d = CMD_MRS; bank_d = BA_W'(MR2_IDX); addr_d = MR2_VAL; end
                ST_MRS3:     begin cmd_d = CMD_MRS; bank_d = BA_W'(MR3_IDX); addr_d = MR3_VAL; end
                ST_MRS1:     begin cmd_d = CMD_MRS; bank_d = BA_W'(MR1_IDX); addr_d = MR1_VAL; end
                ST_MRS0_DLL: begin cmd_d = CMD_MRS; bank_d = BA_W'(MR0_IDX); addr_d = MR0_DLL; end
                ST_MRS0:     begin cmd_d = CMD_MRS; bank_d = BA_W'(MR0_IDX); addr_d = MR0_VAL; end
                ST_ZQCL: begin
                    cmd_d  = CMD_ZQCL;
                    bank_d = '0;
                    addr_d = ADDR_W'(1) << ZQCL_A10_BIT;
                end
                default: ;
            endcase
        end
    end

    // All outputs are registered from the next state so they line up with
    // state_q (and state_dbg) in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            auto_arm    <= AUTO_START;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            dfi_reset_n <= 1'b0;
            dfi_cke     <= 1'b0;
            cmd_q       <= CMD_DESEL;
            dfi_address <= '0;
            dfi_bank    <= '0;
        end else begin
            state_q     <= state_d;
            auto_arm    <= 1'b0;
            busy        <= !(state_d inside {ST_IDLE, ST_DONE});
            init_done   <= (state_d == ST_DONE);
            dfi_reset_n <= !(state_d inside {ST_IDLE, ST_RST_HOLD});
            dfi_cke     <= (state_d >= ST_XPR_WAIT);
            cmd_q       <= cmd_d;
            dfi_address <= addr_d;
            dfi_bank    <= bank_d;
        end
    end

    assign state_dbg = state_q;
    assign dfi_cs_n  = cmd_q.cs_n;
    assign dfi_ras_n = cmd_q.ras_n;
    assign dfi_cas_n = cmd_q.cas_n;
    assign dfi_we_n  = cmd_q.we_n;
    // ODT belongs to the memory controller once init_done flips the mux.
    assign dfi_odt   = 1'b0;

endmodule
